seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
Scheduler and sequencer for the 4-digit 7-segment display of the DPWM board.
- Selects frequency or current as the display source, but only at frame boundaries.
- Converts the selected value to BCD with a multi-cycle double-dabble engine.
- Time-multiplexes the four anodes.
- Feeds one BCD digit at a time to the downstream segment encoder.

Parameters:
SCAN_DIV, 16, clk_d cycles per digit slot; legal range 4..65535.
DATA_W, 10, width of the binary value converted; fixed at 10, so max value is 1023.

Ports:
clk_d  in  1  clock
reset  in  1  reset, synchronous, active-high
control  in  1  source select: 1=frecuencia, 0=corriente
frecuencia  in  8  frequency value, zero-extended to 10 bits
corriente  in  10  current value
blank  in  1  forces all anodes off while high
digito  out  4  anode enables, active-low
digit_sel  out  2  index of the active digit slot, 0=units
bcd_digit  out  4  BCD value of the active digit, to the segment encoder
digit_on  out  1  1 when the active digit is not blanked
frame_start  out  1  one-cycle pulse when digit_sel wraps 3->0
bcd_valid  out  1  display buffer holds a converted value

Behaviour:
Reset values:
- digito=4'b1111, digit_sel=0, bcd_digit=0, digit_on=0, frame_start=0, bcd_valid=0.
- Tick counter, conversion register and display buffer are cleared to 0.
- Conversion FSM goes to SAMPLE.

Scan timing:
- Tick counter runs 0..SCAN_DIV-1.
- At the terminal count, digit_sel increments and wraps 3->0.
- Frame boundary = terminal count with digit_sel==3.
- frame_start is high in the first cycle of digit_sel==0.

Anode mapping (registered; updates on the same edge as digit_sel):
- slot 0 -> 4'b1110, slot 1 -> 4'b1101, slot 2 -> 4'b1011, slot 3 -> 4'b0111.

Blanking:
- Digit k>0 is blanked when it and all higher digits are 0 in the display buffer.
- Slot 0 is never blanked by this rule.
- A blanked slot drives digito=4'b1111 and digit_on=0; bcd_digit still shows the buffer value.
- blank=1 forces digito=4'b1111 and digit_on=0 from the next edge. The scan counter and conversion continue.
- While bcd_valid=0, digito=4'b1111.

Conversion FSM (states SAMPLE, SHIFT, DONE):
- SAMPLE (1 cycle): latch src = control ? {2'b0,frecuencia} : corriente. Clear BCD accumulator. Iteration counter = 0. Go to SHIFT.
- SHIFT (10 cycles): each BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1. After iteration 9, go to DONE.
- DONE: hold the result.
- At each frame boundary:
  - if in DONE, copy the result to the display buffer and set bcd_valid=1 (sticky until reset);
  - re-enter SAMPLE on the next cycle in all cases.
- A frame boundary that arrives while in SAMPLE or SHIFT restarts the conversion and does not copy a result. This cannot happen at legal SCAN_DIV, because the conversion takes 11 cycles and a frame is 4*SCAN_DIV >= 16 cycles.

Latency and source changes:
- After reset release, the first sample is at cycle 0.
- The first display buffer load is at the edge ending cycle 4*SCAN_DIV-1; bcd_valid=1 from cycle 4*SCAN_DIV.
- A value sampled at frame N becomes visible at frame N+1.
- Changes to control, frecuencia or corriente outside SAMPLE are ignored until the next sample.

Other boundary conditions:
- Reset at any time (including mid-SHIFT) aborts the conversion and restores all reset values.
- corriente=1023 displays 1,0,2,3. No saturation or overflow.

Decomposition:
Shared package (seg_disp_pkg):
- anode pattern constants ANODE_D0..ANODE_D3 and ANODE_OFF;
- FSM state encoding SAMPLE/SHIFT/DONE;
- BCD_DIGITS=4 and DATA_W=10.

Sub-module bin2bcd_seq:
- iterative double-dabble: start, 10-bit bin in, 16-bit bcd out, done;
- owns the SAMPLE/SHIFT/DONE FSM.

The top level holds the tick counter, scan, display buffer, blanking and anode logic.

Test Plan:
1. SCAN_DIV=4; reset; control=1, frecuencia=75 -> bcd_valid rises at cycle 16; slot0 digito=1110 bcd 5; slot1 digito=1101 bcd 7; slots 2,3 digito=1111, digit_on=0.
2. control=0, corriente=1000 -> next frames: bcd 0,0,0,1 in slots 0..3; anodes 1110,1101,1011,0111; corriente=1023 -> 3,2,0,1.
3. Value 0 -> slot0 digito=1110, bcd 0; slots 1-3 digito=1111.
4. Display shows frequency 50; toggle control to 0 (corriente=300) mid-frame -> frame in progress and the next frame still show 50; 300 appears at the second frame boundary.
5. blank=1 for 10 cycles -> digito=1111 from the next edge; digit_sel keeps advancing; release restores the correct slot pattern immediately.
6. Assert reset during SHIFT -> all outputs at reset values next cycle; bcd_valid=0 until 4*SCAN_DIV cycles after release.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared constants, FSM encoding and helpers for the 7-segment display scheduler.
// Pure declarations: no state, no latency.
package seg_disp_pkg;

    localparam int DATA_W     = 10;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [3:0] ANODE_D0  = 4'b1110;
    localparam logic [3:0] ANODE_D1  = 4'b1101;
    localparam logic [3:0] ANODE_D2  = 4'b1011;
    localparam logic [3:0] ANODE_D3  = 4'b0111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2
    } conv_state_t;

    // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] anode_for(input logic [1:0] sel);
        logic [3:0] res;
        case (sel)
            2'd0:    res = ANODE_D0;
            2'd1:    res = ANODE_D1;
            2'd2:    res = ANODE_D2;
            default: res = ANODE_D3;
        endcase
        return res;
    endfunction

    // A slot above units is a leading zero when it and every higher digit are zero.
    function automatic logic leading_zero(input logic [BCD_W-1:0] bcd, input logic [1:0] sel);
        logic res;
        res = (sel != 2'd0);
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (i >= int'(sel) && bcd[4*i +: 4] != 4'd0) begin
                res = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Source-select inputs and multiplexed display outputs of the scheduler.
// master = board/stimulus side, slave = the scheduler itself.
interface seg_display_scheduler_if;
    import seg_disp_pkg::*;

    logic              control;
    logic [7:0]        frecuencia;
    logic [DATA_W-1:0] corriente;
    logic              blank;
    logic [3:0]        digito;
    logic [1:0]        digit_sel;
    logic [3:0]        bcd_digit;
    logic              digit_on;
    logic              frame_start;
    logic              bcd_valid;

    modport master (
        output control, frecuencia, corriente, blank,
        input  digito, digit_sel, bcd_digit, digit_on, frame_start, bcd_valid
    );

    modport slave (
        input  control, frecuencia, corriente, blank,
        output digito, digit_sel, bcd_digit, digit_on, frame_start, bcd_valid
    );

endinterface

// File: rtl/seg_display_scheduler_bin2bcd_seq.sv
// Iterative double-dabble: 1 cycle SAMPLE + 10 cycles SHIFT, then DONE holds the result.
// i_start at any time forces SAMPLE on the next cycle, aborting a conversion in flight.
module bin2bcd_seq
    import seg_disp_pkg::*;
(
    input  logic              clk_d,
    input  logic              reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_bin,
    output logic [BCD_W-1:0]  o_bcd,
    output logic              o_done
);

    conv_state_t       r_state;
    conv_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_bin;
    logic [BCD_W-1:0]  r_bcd;
    logic [3:0]        r_iter;
    logic [BCD_W-1:0]  w_adj;
    logic              w_last;

    assign w_adj  = dd_adjust(r_bcd);
    assign w_last = (r_iter == 4'(DATA_W - 1));

    always_ff @(posedge clk_d) begin
        if (reset) begin
            r_state <= SAMPLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_start) begin
            w_state_nxt = SAMPLE;
        end else begin
            case (r_state)
                SAMPLE:  w_state_nxt = SHIFT;
                SHIFT:   w_state_nxt = w_last ? DONE : SHIFT;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = SAMPLE;
            endcase
        end
    end

    always_ff @(posedge clk_d) begin
        if (reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
        end else begin
            case (r_state)
                SAMPLE: begin
                    r_bin  <= i_bin;
                    r_bcd  <= '0;
                    r_iter <= '0;
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_iter         <= r_iter + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_bcd  = r_bcd;
    assign o_done = (r_state == DONE);

endmodule

// File: rtl/seg_display_scheduler.sv
// Scans four 7-segment digits, one slot per SCAN_DIV cycles; value sampled at frame N shows at frame N+1.
// All outputs registered; anode/digit outputs change on the same edge as digit_sel. No backpressure.
module seg_display_scheduler
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic                    clk_d,
    input  logic                    reset,
    seg_display_scheduler_if.slave  bus
);

    logic [15:0]       r_tick;
    logic [1:0]        r_digit_sel;
    logic [BCD_W-1:0]  r_disp_buf;
    logic              r_bcd_valid;
    logic              r_frame_start;
    logic              r_digit_on;
    logic [3:0]        r_digito;
    logic [3:0]        r_bcd_digit;

    logic              w_tc;
    logic              w_frame;
    logic              w_done;
    logic              w_load;
    logic              w_valid_nxt;
    logic              w_show;
    logic [1:0]        w_sel_nxt;
    logic [BCD_W-1:0]  w_bcd;
    logic [BCD_W-1:0]  w_buf_nxt;
    logic [DATA_W-1:0] w_src;

    assign w_src = bus.control ? {2'b00, bus.frecuencia} : bus.corriente;

    bin2bcd_seq u_bin2bcd (
        .clk_d   (clk_d),
        .reset   (reset),
        .i_start (w_frame),
        .i_bin   (w_src),
        .o_bcd   (w_bcd),
        .o_done  (w_done)
    );

    assign w_tc        = (r_tick == 16'(SCAN_DIV - 1));
    assign w_frame     = w_tc && (r_digit_sel == 2'd3);
    assign w_sel_nxt   = w_tc ? r_digit_sel + 2'd1 : r_digit_sel;
    assign w_load      = w_frame && w_done;
    assign w_buf_nxt   = w_load ? w_bcd : r_disp_buf;
    assign w_valid_nxt = r_bcd_valid | w_load;

    // Registered outputs are derived from next-cycle slot and buffer so they line up with digit_sel.
    assign w_show = w_valid_nxt && !bus.blank && !leading_zero(w_buf_nxt, w_sel_nxt);

    always_ff @(posedge clk_d) begin
        if (reset) begin
            r_tick        <= '0;
            r_digit_sel   <= '0;
            r_disp_buf    <= '0;
            r_bcd_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_digit_on    <= 1'b0;
            r_digito      <= ANODE_OFF;
            r_bcd_digit   <= '0;
        end else begin
            r_tick        <= w_tc ? 16'd0 : r_tick + 16'd1;
            r_digit_sel   <= w_sel_nxt;
            r_disp_buf    <= w_buf_nxt;
            r_bcd_valid   <= w_valid_nxt;
            r_frame_start <= w_frame;
            r_digit_on    <= w_show;
            r_digito      <= w_show ? anode_for(w_sel_nxt) : ANODE_OFF;
            r_bcd_digit   <= w_buf_nxt[{w_sel_nxt, 2'b00} +: 4];
        end
    end

    assign bus.digito      = r_digito;
    assign bus.digit_sel   = r_digit_sel;
    assign bus.bcd_digit   = r_bcd_digit;
    assign bus.digit_on    = r_digit_on;
    assign bus.frame_start = r_frame_start;
    assign bus.bcd_valid   = r_bcd_valid;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: directed scenarios then randomized inputs against a frame-level model.
module tb_seg_display_scheduler;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic clk_d = 1'b0;
    logic reset = 1'b1;

    seg_display_scheduler_if bus();

    seg_display_scheduler #(.SCAN_DIV(SD)) dut (
        .clk_d (clk_d),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_d = ~clk_d;

    int n_vec = 0;
    int n_err = 0;

    // Model state: position within the frame, shown value, value waiting for next frame.
    int   m_pos, m_disp, m_pend, m_rel;
    bit   m_valid, m_seen;
    int   e_sel, e_dig, e_on, e_bcd, e_fs, e_valid;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    task automatic model_step();
        bit bnd;
        bit show;
        int sel;
        if (reset) begin
            m_pos = 0; m_disp = 0; m_pend = 0; m_valid = 0; m_rel = 0; m_seen = 0;
            e_sel = 0; e_dig = 15; e_on = 0; e_bcd = 0; e_fs = 0; e_valid = 0;
        end else begin
            if (m_pos == 0) m_pend = bus.control ? int'(bus.frecuencia) : int'(bus.corriente);
            bnd = (m_pos == FRAME - 1);
            if (bnd) begin
                m_disp  = m_pend;
                m_valid = 1;
            end
            m_pos = bnd ? 0 : m_pos + 1;
            m_rel++;
            sel  = m_pos / SD;
            show = m_valid && !bus.blank && (sel == 0 || m_disp >= pow10(sel));
            e_sel   = sel;
            e_fs    = bnd;
            e_valid = m_valid;
            e_on    = show;
            e_dig   = show ? 15 - (1 << sel) : 15;
            e_bcd   = (m_disp / pow10(sel)) % 10;
        end
    endtask

    task automatic step();
        @(posedge clk_d);
        model_step();
        @(negedge clk_d);
        chk("digito",      bus.digito,      e_dig);
        chk("digit_sel",   bus.digit_sel,   e_sel);
        chk("bcd_digit",   bus.bcd_digit,   e_bcd);
        chk("digit_on",    bus.digit_on,    e_on);
        chk("frame_start", bus.frame_start, e_fs);
        chk("bcd_valid",   bus.bcd_valid,   e_valid);
        if (!m_seen && bus.bcd_valid) begin
            chk("valid_rise_cycle", m_rel, FRAME);
            m_seen = 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.control    = 1'b1;
        bus.frecuencia = 8'd75;
        bus.corriente  = 10'd0;
        bus.blank      = 1'b0;
        reset          = 1'b1;
        run(3);
        reset = 1'b0;
        run(3 * FRAME);

        bus.control   = 1'b0;
        bus.corriente = 10'd1000;
        run(3 * FRAME);
        bus.corriente = 10'd1023;
        run(3 * FRAME);
        bus.corriente = 10'd0;
        run(3 * FRAME);

        // Source switch mid-frame: old value must persist one extra frame.
        bus.control    = 1'b1;
        bus.frecuencia = 8'd50;
        run(3 * FRAME + SD + 1);
        bus.control   = 1'b0;
        bus.corriente = 10'd300;
        run(3 * FRAME);

        bus.corriente = 10'd4;
        run(2 * FRAME);
        bus.blank = 1'b1;
        run(10);
        bus.blank = 1'b0;
        run(FRAME);

        // Reset landing in the middle of a conversion.
        for (int i = 0; i < FRAME && m_pos != 3; i++) step();
        chk("reached_shift_pos", m_pos, 3);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(2 * FRAME);

        for (int seg = 0; seg < 60; seg++) begin
            bus.control    = 1'($urandom_range(0, 1));
            bus.frecuencia = 8'($urandom_range(0, 255));
            bus.corriente  = 10'($urandom_range(0, 1023));
            bus.blank      = ($urandom_range(0, 5) == 0);
            reset          = ($urandom_range(0, 14) == 0);
            run(1);
            reset = 1'b0;
            run($urandom_range(1, 2 * FRAME));
        end
        bus.blank = 1'b0;
        run(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
